// File: rtl/serial_tx_arb_if.sv
// serial_tx_arb_if: bundles the requester-side and transmitter-side signals of
// serial_tx_arb.
//   master : protocol engines / bench (drive req, data, nbits, n0, n1)
//   slave  : serial_tx_arb (drives grant, done, abort, busy and the tx_* fields)
// Requester i data sits in req_data[256*i +: 256] and its bit count in
// req_nbits[8*i +: 8].
interface serial_tx_arb_if #(
  parameter int unsigned NREQ = 4
) ();

  logic [NREQ-1:0]     req;
  logic [NREQ*256-1:0] req_data;
  logic [NREQ*8-1:0]   req_nbits;
  logic [31:0]         n0;
  logic [31:0]         n1;

  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                abort;
  logic                busy;
  logic                tx_rst;
  logic [255:0]        tx_data;
  logic [7:0]          tx_nbits;
  logic [31:0]         tx_n0;
  logic [31:0]         tx_n1;
  logic [31:0]         tx_cnt;

  modport master (
    output req, req_data, req_nbits, n0, n1,
    input  grant, done, abort, busy, tx_rst, tx_data, tx_nbits, tx_n0, tx_n1, tx_cnt
  );

  modport slave (
    input  req, req_data, req_nbits, n0, n1,
    output grant, done, abort, busy, tx_rst, tx_data, tx_nbits, tx_n0, tx_n1, tx_cnt
  );

endinterface

// File: rtl/serial_tx_arb.sv
// serial_tx_arb: shares one serial_tx transmitter between NREQ requesters.
// Picks a winner (round-robin, or fixed priority when SERIAL_TX_ARB_PRIO_EN is
// defined), latches its data/nbits plus the shared n0/n1 timing with zero
// clamped to one, drives the transmitter timebase (tx_cnt) and reset (tx_rst),
// pulses done[g] on the last bit period, then holds tx_rst for a guard gap.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_tx_arb_if.slave (req/req_data/req_nbits/n0/n1 in;
//                grant/done/abort/busy/tx_rst/tx_data/tx_nbits/tx_n0/tx_n1/
//                tx_cnt out, all registered)
// Parameters: NREQ (2..8) requesters, GAP guard cycles (0 behaves as 1).
// Optional macro: SERIAL_TX_ARB_PRIO_EN -> lowest index wins, pointer held 0.
module serial_tx_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_tx_arb_if.slave bus
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GAPC = (GAP == 0) ? 1 : GAP;
  localparam int unsigned GW   = $clog2(GAPC + 1);
  localparam int unsigned DW   = 256;
  localparam int unsigned NBW  = 8;
  localparam int unsigned TW   = 32;
  localparam int unsigned RW   = 41;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            abort_q;
  logic            busy_q;
  logic            tx_rst_q;
  logic [DW-1:0]   data_q;
  logic [NBW-1:0]  nbits_q;
  logic [TW-1:0]   n0_q;
  logic [TW-1:0]   n1_q;
  logic [RW-1:0]   end_q;
  logic [RW-1:0]   run_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gidx_q;
  logic [GW-1:0]   gap_q;

  // Winner search: first set req at or after the pointer, wrapping.
  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NREQ);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Winner fields with zero clamped to one, and the 41-bit end count.
  logic [DW-1:0]  sel_data;
  logic [NBW-1:0] sel_nbits;
  logic [NBW-1:0] nb_c;
  logic [TW-1:0]  n0_c;
  logic [TW-1:0]  n1_c;
  logic [RW-1:0]  end_d;

  always_comb begin
    sel_data  = bus.req_data[DW*sel_idx +: DW];
    sel_nbits = bus.req_nbits[NBW*sel_idx +: NBW];
    nb_c      = (sel_nbits == '0) ? NBW'(1) : sel_nbits;
    n0_c      = (bus.n0 == '0) ? TW'(1) : bus.n0;
    n1_c      = (bus.n1 == '0) ? TW'(1) : bus.n1;
    end_d     = RW'(n0_c) + RW'(nb_c) * RW'(n1_c);
  end

  // Pointer after a transfer ends (done or abort).
  logic [PW-1:0] ptr_d;

  always_comb begin
`ifdef SERIAL_TX_ARB_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = PW'((32'(gidx_q) + 1) % NREQ);
`endif
  end

  // Completion has priority over a dropped request in the same cycle.
  logic          req_g;
  logic          fin_c;
  logic          abt_c;
  logic [RW-1:0] run_inc;

  always_comb begin
    req_g   = bus.req[gidx_q];
    fin_c   = (state_q == S_RUN) && (run_q == end_q);
    abt_c   = ((state_q == S_LOAD) || (state_q == S_RUN)) && !req_g && !fin_c;
    run_inc = run_q + RW'(1);
  end

  // Sequencer: state, latched fields, timebase and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      tx_rst_q <= 1'b1;
      data_q   <= '0;
      nbits_q  <= '0;
      n0_q     <= TW'(1);
      n1_q     <= TW'(1);
      end_q    <= '0;
      run_q    <= '0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      gap_q    <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_rst_q <= 1'b1;
          run_q    <= '0;
          busy_q   <= 1'b0;
          if (sel_found) begin
            data_q   <= sel_data;
            nbits_q  <= nb_c;
            n0_q     <= n0_c;
            n1_q     <= n1_c;
            end_q    <= end_d;
            gidx_q   <= sel_idx;
            grant_q  <= NREQ'(1) << sel_idx;
            busy_q   <= 1'b1;
            tx_rst_q <= 1'b0;
            state_q  <= S_LOAD;
          end
        end

        S_LOAD, S_RUN: begin
          if (fin_c || abt_c) begin
            abort_q  <= abt_c;
            grant_q  <= '0;
            ptr_q    <= ptr_d;
            gap_q    <= GW'(GAPC);
            tx_rst_q <= 1'b1;
            run_q    <= '0;
            state_q  <= S_GAP;
          end else if (state_q == S_LOAD) begin
            // Run counter reads 1 on the first RUN cycle.
            run_q   <= RW'(1);
            state_q <= S_RUN;
          end else begin
            run_q <= run_inc;
            // Registered so done lines up with the cycle tx_cnt equals end.
            if (run_inc == end_q) begin
              done_q <= grant_q;
            end
          end
        end

        S_GAP: begin
          tx_rst_q <= 1'b1;
          run_q    <= '0;
          if (gap_q == GW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end

        default: begin
          grant_q  <= '0;
          busy_q   <= 1'b0;
          tx_rst_q <= 1'b1;
          run_q    <= '0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.abort    = abort_q;
  assign bus.busy     = busy_q;
  assign bus.tx_rst   = tx_rst_q;
  assign bus.tx_data  = data_q;
  assign bus.tx_nbits = nbits_q;
  assign bus.tx_n0    = n0_q;
  assign bus.tx_n1    = n1_q;
  assign bus.tx_cnt   = run_q[TW-1:0];

endmodule

// File: tb/tb_serial_tx_arb.sv
// tb_serial_tx_arb: directed self-checking bench for serial_tx_arb
// (NREQ=4, GAP=2). Outputs are sampled on the falling clock edge.
module tb_serial_tx_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned GAP  = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  serial_tx_arb_if #(.NREQ(NREQ)) bus ();

  serial_tx_arb #(.NREQ(NREQ), .GAP(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_grant"},  64'(bus.grant),    64'd0);
    chk({tag, "_done"},   64'(bus.done),     64'd0);
    chk({tag, "_abort"},  64'(bus.abort),    64'd0);
    chk({tag, "_busy"},   64'(bus.busy),     64'd0);
    chk({tag, "_txrst"},  64'(bus.tx_rst),   64'd1);
    chk({tag, "_cnt"},    64'(bus.tx_cnt),   64'd0);
    chk({tag, "_nbits"},  64'(bus.tx_nbits), 64'd0);
    chk({tag, "_n0"},     64'(bus.tx_n0),    64'd1);
    chk({tag, "_n1"},     64'(bus.tx_n1),    64'd1);
    chk({tag, "_data"},   bus.tx_data[63:0], 64'd0);
  endtask

  // Called on the LOAD cycle; returns on the cycle done pulses.
  task automatic run_xfer(input logic [NREQ-1:0] g, input int endc);
    chk("load_grant", 64'(bus.grant),  64'(g));
    chk("load_busy",  64'(bus.busy),   64'd1);
    chk("load_txrst", 64'(bus.tx_rst), 64'd0);
    chk("load_cnt",   64'(bus.tx_cnt), 64'd0);
    chk("load_done",  64'(bus.done),   64'd0);
    for (int k = 1; k <= endc; k++) begin
      tick();
      chk("run_cnt",   64'(bus.tx_cnt), 64'(k));
      chk("run_grant", 64'(bus.grant),  64'(g));
      chk("run_txrst", 64'(bus.tx_rst), 64'd0);
      chk("run_done",  64'(bus.done),   (k == endc) ? 64'(g) : 64'd0);
      chk("run_abort", 64'(bus.abort),  64'd0);
    end
  endtask

  // From GAP cycle 1: second GAP cycle, then IDLE.
  task automatic gap_rest();
    tick();
    chk("gap2_txrst", 64'(bus.tx_rst), 64'd1);
    chk("gap2_busy",  64'(bus.busy),   64'd1);
    chk("gap2_abort", 64'(bus.abort),  64'd0);
    chk("gap2_grant", 64'(bus.grant),  64'd0);
    tick();
    chk("idle_busy",  64'(bus.busy),   64'd0);
    chk("idle_txrst", 64'(bus.tx_rst), 64'd1);
    chk("idle_cnt",   64'(bus.tx_cnt), 64'd0);
  endtask

  // From the done cycle: first GAP cycle then the rest.
  task automatic gap_chk();
    tick();
    chk("gap1_grant", 64'(bus.grant),  64'd0);
    chk("gap1_txrst", 64'(bus.tx_rst), 64'd1);
    chk("gap1_busy",  64'(bus.busy),   64'd1);
    chk("gap1_done",  64'(bus.done),   64'd0);
    chk("gap1_cnt",   64'(bus.tx_cnt), 64'd0);
    gap_rest();
  endtask

  logic [255:0]    d0;
  logic [NREQ-1:0] exp_g;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_nbits = '0;
    bus.n0        = 32'd2;
    bus.n1        = 32'd3;
    d0 = {64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
          64'h5555_6666_7777_8888, 64'hDEAD_BEEF_CAFE_00A5};
    bus.req_data[255:0]   = d0;
    bus.req_data[511:256] = ~d0;
    bus.req_nbits[7:0]    = 8'd8;
    bus.req_nbits[15:8]   = 8'd4;
    bus.req_nbits[23:16]  = 8'd1;
    bus.req_nbits[31:24]  = 8'd1;
    tick();
    tick();
    rst_chk("por");
    rst_n = 1'b1;
    tick();

    // Single request: end = 2 + 8*3 = 26.
    bus.req = 4'b0001;
    tick();
    run_xfer(4'b0001, 26);
    chk("b_data_lo", bus.tx_data[63:0],    d0[63:0]);
    chk("b_data_hi", bus.tx_data[255:192], d0[255:192]);
    chk("b_nbits",   64'(bus.tx_nbits),    64'd8);
    chk("b_n0",      64'(bus.tx_n0),       64'd2);
    chk("b_n1",      64'(bus.tx_n1),       64'd3);
    bus.req = 4'b0000;
    gap_chk();

    // Two simultaneous requests from reset: req1 (end 14) then req2 (end 5).
    rst_n = 1'b0;
    tick();
    rst_chk("rst2");
    rst_n = 1'b1;
    tick();
    bus.req = 4'b0110;
    tick();
    run_xfer(4'b0010, 14);
    bus.req = 4'b0100;
    gap_chk();
    tick();
    run_xfer(4'b0100, 5);
    bus.req = 4'b1001;
    gap_chk();
    tick();
`ifdef SERIAL_TX_ARB_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b1000;
`endif
    chk("ptr3_grant", 64'(bus.grant), 64'(exp_g));
    // Drop during LOAD -> abort.
    bus.req = 4'b0000;
    tick();
    chk("lab_abort", 64'(bus.abort),  64'd1);
    chk("lab_grant", 64'(bus.grant),  64'd0);
    chk("lab_txrst", 64'(bus.tx_rst), 64'd1);
    chk("lab_done",  64'(bus.done),   64'd0);
    gap_rest();

    // Clamp: nbits=0, n0=0, n1=0 -> 1/1/1, end = 2.
    bus.req_nbits[23:16] = 8'd0;
    bus.n0  = 32'd0;
    bus.n1  = 32'd0;
    bus.req = 4'b0100;
    tick();
    run_xfer(4'b0100, 2);
    chk("c_nbits", 64'(bus.tx_nbits), 64'd1);
    chk("c_n0",    64'(bus.tx_n0),    64'd1);
    chk("c_n1",    64'(bus.tx_n1),    64'd1);
    bus.req = 4'b0000;
    gap_chk();

    // Abort mid-RUN: req0 nbits=16, n1=4, dropped at RUN cycle 5; req1 waits.
    bus.req_nbits[7:0] = 8'd16;
    bus.n0  = 32'd2;
    bus.n1  = 32'd4;
    bus.req = 4'b0011;
    tick();
    chk("e_grant", 64'(bus.grant),    64'd1);
    chk("e_nbits", 64'(bus.tx_nbits), 64'd16);
    chk("e_n1",    64'(bus.tx_n1),    64'd4);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("e_cnt",  64'(bus.tx_cnt), 64'(k));
      chk("e_done", 64'(bus.done),   64'd0);
    end
    bus.req = 4'b0010;
    bus.n1  = 32'd3;
    tick();
    chk("e_abort", 64'(bus.abort),  64'd1);
    chk("e_adone", 64'(bus.done),   64'd0);
    chk("e_agnt",  64'(bus.grant),  64'd0);
    chk("e_txrst", 64'(bus.tx_rst), 64'd1);
    chk("e_acnt",  64'(bus.tx_cnt), 64'd0);
    gap_rest();
    tick();
    chk("e_next_grant", 64'(bus.grant),  64'd2);
    chk("e_next_txrst", 64'(bus.tx_rst), 64'd0);

    // Reset mid-RUN, then a clean full transfer for the pending req1 (end 14).
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("f_cnt", 64'(bus.tx_cnt), 64'(k));
    end
    rst_n = 1'b0;
    #1;
    rst_chk("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    run_xfer(4'b0010, 14);
    chk("f_nbits", 64'(bus.tx_nbits), 64'd4);
    bus.req = 4'b0000;
    gap_chk();

`ifdef SERIAL_TX_ARB_PRIO_EN
    // Fixed priority: req0 and req3 held, req0 always wins (end 2+1*3=5).
    bus.req_nbits[7:0] = 8'd1;
    bus.req = 4'b1001;
    for (int r = 0; r < 3; r++) begin
      tick();
      run_xfer(4'b0001, 5);
      gap_chk();
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_tx_arb.md
Name: serial_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one serial_tx transmitter between NREQ requesters.
- Owns the transmitter's cnt timebase and reset, and latches the winner's data, bit count and timing.
- Pulses a per-requester done when the last bit period ends, then holds the transmitter in reset for a guard gap.
- Sits between protocol engines (config shifters, DAC/ASIC loaders) and a single serial output pin.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP, 2, guard cycles with tx_rst high between transfers (0 treated as 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; hold high until done
req_data  in  NREQ*256  requester i data in bits [256*i+255:256*i], msb-aligned per nbits
req_nbits  in  NREQ*8  requester i bit count in bits [8*i+7:8*i]
n0  in  32  start delay in cnt cycles, shared
n1  in  32  bit period in cnt cycles, shared
grant  out  NREQ  one-hot, high from LOAD through end of RUN
done  out  NREQ  one-cycle pulse to the granted requester on completion
abort  out  1  one-cycle pulse when the granted req drops during LOAD/RUN
busy  out  1  high in any state other than IDLE
tx_rst  out  1  active-high reset to serial_tx
tx_data  out  256  latched data
tx_nbits  out  8  latched nbits, 0 clamped to 1
tx_n0  out  32  latched n0, 0 clamped to 1
tx_n1  out  32  latched n1, 0 clamped to 1
tx_cnt  out  32  timebase, low 32 bits of the internal run counter

Behaviour:
- Reset (rst_n low, async): state IDLE; grant=0, done=0, abort=0, busy=0, tx_rst=1, tx_cnt=0, tx_data/nbits=0, tx_n0=tx_n1=1; round-robin pointer=0.
- IDLE:
  - tx_rst=1, tx_cnt=0.
  - If any req is high, select the first set req at or after the pointer, wrapping modulo NREQ.
  - Latch data, nbits, n0 and n1 with clamps applied.
  - Compute end = n0 + nbits*n1 as a 41-bit unsigned value.
  - Set grant and go to LOAD. Grant is visible the cycle after req is sampled.
- LOAD (exactly 1 cycle):
  - tx_rst=0, tx_cnt=0.
  - The transmitter loads its compare registers during this cycle. Because clamped n0 is at least 1, cnt=0 never starts a bit.
  - Go to RUN.
- RUN:
  - The 41-bit run counter starts at 1 on the first RUN cycle and increments by 1 each cycle; tx_cnt is its low 32 bits.
  - When run counter == end: pulse done[g] the same cycle, clear grant next cycle, advance the pointer to g+1, and go to GAP.
  - Total transfer = 1 (LOAD) + end RUN cycles.
- Abort: if req[g] is low in LOAD or RUN, pulse abort, clear grant, advance the pointer, go to GAP with tx_rst=1. No done pulse.
- GAP:
  - tx_rst=1, tx_cnt=0.
  - A down-counter loads max(GAP,1) on entry; exit to IDLE when it reaches 0.
  - Requests are not sampled in GAP.
- Other requester signals: req changes by non-granted requesters never affect the current transfer. Latched fields are frozen from IDLE exit until the next IDLE.
- Simultaneous events: done and abort cannot occur together; done wins when req[g] falls in the same cycle the end count is reached.
- Illegal state encodings go to IDLE.

Optional Feature:
- Macro SERIAL_TX_ARB_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined: round-robin as above.

Test Plan:
- Single request req[0], nbits=8, n0=2, n1=3 -> grant[0] one cycle after req; end=26; done[0] pulses on the 26th RUN cycle (tx_cnt=26); tx_rst high for 2 cycles afterward; the y bit-stream matches data[7:0] msb-first.
- req[1] and req[2] raised together from reset -> req[1] served first, then req[2]; grant is never multi-hot; pointer=3 afterward.
- nbits=0, n0=0, n1=0 -> clamped to 1/1/1; end=2; done after 2 RUN cycles; exactly one data bit is emitted.
- req[0] dropped at RUN cycle 5 of a nbits=16, n1=4 transfer -> abort pulse; no done; tx_rst=1 next cycle; next requester granted after GAP.
- rst_n asserted mid-RUN -> all outputs return to their reset values immediately; after release, a pending req gets a clean full transfer.
- With SERIAL_TX_ARB_PRIO_EN, req[0] and req[3] held continuously -> req[0] is granted repeatedly and req[3] is never granted.
